bit_serializer: RTL and testbench



---
 rtl/bit_serializer.sv | 147 ++++++++++++++
 tb/tb_bit_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-load serializer: one word in over valid/ready, one bit per clock out on x_out.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 2,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2, S_PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_GAP = 2'd2} state_t;
`endif

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_x_out;
  logic             r_bit_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;
`ifdef SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  logic [WIDTH-1:0] w_shift_next;
  logic             w_next_bit;

  // Rotating keeps every register bit live; only the bit at the output end matters.
  assign w_shift_next = MSB_FIRST ? {r_shift[WIDTH-2:0], r_shift[WIDTH-1]}
                                  : {r_shift[0], r_shift[WIDTH-1:1]};
  assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-2] : r_shift[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_gap_cnt    <= '0;
      r_x_out      <= IDLE_LEVEL;
      r_bit_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_state      <= S_SHIFT;
            r_shift      <= data_in;
            r_cnt        <= CNT_LOAD;
            r_x_out      <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
            r_bit_valid  <= 1'b1;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            r_parity     <= ^data_in;
`endif
          end
        end

        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
            r_shift <= w_shift_next;
            r_x_out <= w_next_bit;
`ifndef SERIALIZER_PARITY_EN
            r_done  <= (r_cnt == CW'(1));
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            r_state <= S_PARITY;
            r_x_out <= r_parity;
            r_done  <= 1'b1;
`else
            r_state      <= HAS_GAP ? S_GAP : S_IDLE;
            r_gap_cnt    <= GAP_LOAD;
            r_x_out      <= IDLE_LEVEL;
            r_bit_valid  <= 1'b0;
            r_busy       <= HAS_GAP;
            r_load_ready <= !HAS_GAP;
`endif
          end
        end

`ifdef SERIALIZER_PARITY_EN
        S_PARITY: begin
          r_state      <= HAS_GAP ? S_GAP : S_IDLE;
          r_gap_cnt    <= GAP_LOAD;
          r_x_out      <= IDLE_LEVEL;
          r_bit_valid  <= 1'b0;
          r_busy       <= HAS_GAP;
          r_load_ready <= !HAS_GAP;
        end
`endif

        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_load_ready <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_x_out      <= IDLE_LEVEL;
          r_bit_valid  <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign x_out      = r_x_out;
  assign bit_valid  = r_bit_valid;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances, table vectors, random words, corner sequences.
module tb_bit_serializer;

  localparam int W = 8;
  localparam int G = 2;
`ifdef SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int SPAN = W + P + G + 1;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         load_valid = 1'b0;
  logic         use_lsb = 1'b0;

  logic lv_m, rdy_m, x_m, bv_m, busy_m, done_m;
  logic lv_l, rdy_l, x_l, bv_l, busy_l, done_l;
  logic rdy, x, bv, bsy, dn;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  assign lv_m = load_valid & ~use_lsb;
  assign lv_l = load_valid & use_lsb;
  assign rdy  = use_lsb ? rdy_l  : rdy_m;
  assign x    = use_lsb ? x_l    : x_m;
  assign bv   = use_lsb ? bv_l   : bv_m;
  assign bsy  = use_lsb ? busy_l : busy_m;
  assign dn   = use_lsb ? done_l : done_m;

  bit_serializer dut_msb (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(lv_m),
    .load_ready(rdy_m), .x_out(x_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
  );

  bit_serializer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(lv_l),
    .load_ready(rdy_l), .x_out(x_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
  );

  typedef struct {
    logic [7:0] d;
    logic       lsb;
    logic [7:0] s;    // expected data bits, first transmitted bit leftmost
    logic       par;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_x"}, x, 1'b1);
    check({tag, "_rdy"}, rdy, 1'b1);
    check({tag, "_busy"}, bsy, 1'b0);
    check({tag, "_bv"}, bv, 1'b0);
    check({tag, "_done"}, dn, 1'b0);
  endtask

  // Reference: a word occupies W data cycles, P parity cycles, G gap cycles, then idle.
  function automatic logic model_x(input logic lsb, input logic [7:0] d, input int c);
    if (c <= W) return lsb ? d[c-1] : d[W-c];
    if (c <= W + P) return ^d;
    return 1'b1;
  endfunction

  // Called at a negedge; drives an accept and checks every cycle of the word.
  task automatic run_word(input logic lsb, input logic [7:0] d,
                          output logic [7:0] stream, output logic par);
    int waited;
    use_lsb = lsb;
    waited = 0;
    while (!rdy && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    check("ready_wait", rdy, 1'b1);
    data_in = d;
    load_valid = 1'b1;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    data_in = W'($urandom);
    stream = '0;
    par = 1'b0;
    for (int c = 1; c <= SPAN; c++) begin
      @(negedge clock);
      check("word_x", x, model_x(lsb, d, c));
      check("word_bv", bv, c <= W + P);
      check("word_done", dn, c == W + P);
      check("word_rdy", rdy, c == SPAN);
      check("word_busy", bsy, c < SPAN);
      if (c <= W) stream = {stream[6:0], x};
      if (c == W + 1) par = x;
    end
    $display("word lsb=%0b data=%02h stream=%b par=%b", lsb, d, stream, par);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s;
    logic       p;

    vecs[0]  = '{8'hA5, 1'b0, 8'b10100101, 1'b0};
    vecs[1]  = '{8'hA5, 1'b1, 8'b10100101, 1'b0};
    vecs[2]  = '{8'h0F, 1'b1, 8'b11110000, 1'b0};
    vecs[3]  = '{8'h0F, 1'b0, 8'b00001111, 1'b0};
    vecs[4]  = '{8'h07, 1'b0, 8'b00000111, 1'b1};
    vecs[5]  = '{8'h3C, 1'b1, 8'b00111100, 1'b0};
    vecs[6]  = '{8'h80, 1'b0, 8'b10000000, 1'b1};
    vecs[7]  = '{8'h80, 1'b1, 8'b00000001, 1'b1};
    vecs[8]  = '{8'h01, 1'b1, 8'b10000000, 1'b1};
    vecs[9]  = '{8'hFF, 1'b0, 8'b11111111, 1'b0};
    vecs[10] = '{8'h00, 1'b1, 8'b00000000, 1'b0};
    vecs[11] = '{8'h96, 1'b0, 8'b10010110, 1'b0};
    vecs[12] = '{8'h96, 1'b1, 8'b01101001, 1'b0};
    vecs[13] = '{8'h5B, 1'b1, 8'b11011010, 1'b1};

    // Reset held low for three cycles, then idle after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      use_lsb = 1'b0; #1; check_idle("rst_m");
      use_lsb = 1'b1; #1; check_idle("rst_l");
    end
    @(negedge clock);
    reset = 1'b1;
    use_lsb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_idle("post_rst");
    end

    // Table vectors
    for (int i = 0; i < 14; i++) begin
      run_word(vecs[i].lsb, vecs[i].d, s, p);
      for (int b = 0; b < 8; b++) check("tbl_stream", s[b], vecs[i].s[b]);
`ifdef SERIALIZER_PARITY_EN
      check("tbl_parity", p, vecs[i].par);
`endif
    end

    // Load attempt while busy must be ignored
    use_lsb = 1'b0;
    data_in = 8'h00;
    load_valid = 1'b1;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    for (int c = 1; c <= SPAN + 5; c++) begin
      @(negedge clock);
      check("ign_x", x, c > W + P ? 1'b1 : (c == W + 1 ? 1'b0 : 1'b0));
      check("ign_bv", bv, c <= W + P);
      check("ign_done", dn, c == W + P);
      check("ign_busy", bsy, c < SPAN);
      if (c == 4) begin
        load_valid = 1'b1;
        data_in = 8'hFF;
      end else begin
        load_valid = 1'b0;
      end
    end
    $display("word busy-ignore data=00 stray=FF");

    // Reset asserted mid-word
    use_lsb = 1'b0;
    data_in = 8'hC3;
    load_valid = 1'b1;
    @(posedge clock);
    #1;
    load_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    check("mid_busy_before", bsy, 1'b1);
    reset = 1'b0;
    #1;
    check("mid_x", x, 1'b1);
    check("mid_busy", bsy, 1'b0);
    check("mid_bv", bv, 1'b0);
    check("mid_rdy", rdy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check_idle("mid_hold");
    end
    reset = 1'b1;
    run_word(1'b0, 8'h3C, s, p);
    check("mid_after_stream", s == 8'b00111100, 1'b1);
    $display("word mid-reset recovery data=3C");

    // Random words with random idle spacing, including back-to-back
    for (int i = 0; i < 40; i++) begin
      logic       lsb_r;
      logic [7:0] d_r;
      lsb_r = 1'($urandom_range(0, 1));
      d_r   = 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_word(lsb_r, d_r, s, p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
